// File: rtl/actuator_array.sv
// actuator_array
//   Per-channel saturating transfer for a bank of actuator drive samples.
//   Mode 0 (softsign): y = sign(x) * floor(|x| * 2^FRAC / (2^FRAC + |x|)),
//   evaluated with one shared restoring divider, one quotient bit per cycle.
//   Mode 1 (hard clip): y = clamp(x, -(2^FRAC-1), 2^FRAC-1).
//
// Ports
//   iClk    rising-edge clock
//   iRst    asynchronous active-high reset
//   iData   CHANNELS packed signed samples, channel k at [k*WIDTH +: WIDTH]
//   iValid  input transaction valid
//   oReady  block can accept a transaction (IDLE only)
//   iMode   0 = softsign, 1 = symmetric hard clip
//   oData   CHANNELS packed signed results, same lane layout as iData
//   oValid  oData holds a complete result
//   iReady  downstream accepts the result
//   oBusy   transaction in progress
//
// State | meaning
//   IDLE  | waiting for iValid; oReady = 1
//   LOAD  | one cycle per channel: divider operand setup (mode 0) or clip (mode 1)
//   DIV   | WIDTH+FRAC cycles per channel, one quotient bit each
//   DONE  | result presented; held until iReady

module actuator_array #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [CHANNELS*WIDTH-1:0] iData,
    input  logic                      iValid,
    output logic                      oReady,
    input  logic                      iMode,
    output logic [CHANNELS*WIDTH-1:0] oData,
    output logic                      oValid,
    input  logic                      iReady,
    output logic                      oBusy
);

    localparam int NB   = WIDTH + FRAC;
    localparam int CNTW = $clog2(NB);
    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CHW-1:0]          LAST_CH = CHW'(CHANNELS - 1);
    localparam logic signed [WIDTH-1:0] POS_LIM = WIDTH'((1 << FRAC) - 1);
    localparam logic signed [WIDTH-1:0] NEG_LIM = -POS_LIM;
    localparam logic [WIDTH:0]          UNITY   = (WIDTH+1)'(1 << FRAC);

    logic [1:0]                state_q, state_d;
    logic                      mode_q, mode_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [CHW-1:0]            ch_q, ch_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic                      neg_q, neg_d;
    logic [WIDTH:0]            rem_q, rem_d;
    logic [NB-1:0]             num_q, num_d;
    logic [WIDTH:0]            den_q, den_d;
    logic [WIDTH-1:0]          buf_q [CHANNELS];
    logic [WIDTH-1:0]          buf_d [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] out_q, out_d;

    logic [WIDTH-1:0]          lane_in [CHANNELS];
    logic signed [WIDTH-1:0]   cur_x;
    logic                      cur_neg;
    logic [WIDTH:0]            cur_abs;
    logic signed [WIDTH-1:0]   clip_val;
    logic [WIDTH+1:0]          rem_shift;
    logic [WIDTH+1:0]          rem_sub;
    logic                      q_bit;
    logic [NB-1:0]             quo;
    logic                      lane_done;
    logic [WIDTH-1:0]          lane_val;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        assign lane_in[g] = data_q[g*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rem_d   = rem_q;
        num_d   = num_q;
        den_d   = den_q;
        buf_d   = buf_q;
        out_d   = out_q;

        cur_x   = $signed(lane_in[ch_q]);
        cur_neg = cur_x[WIDTH-1];
        // Sign-extend before negating so -2^(WIDTH-1) yields an exact magnitude.
        cur_abs = cur_neg ? -{cur_x[WIDTH-1], cur_x} : {1'b0, cur_x};

        if (cur_x > POS_LIM) begin
            clip_val = POS_LIM;
        end else if (cur_x < NEG_LIM) begin
            clip_val = NEG_LIM;
        end else begin
            clip_val = cur_x;
        end

        // Restoring step: num_q shifts dividend bits out of its MSB and
        // quotient bits into its LSB, so after NB steps it holds the quotient.
        rem_shift = {rem_q, num_q[NB-1]};
        rem_sub   = rem_shift - {1'b0, den_q};
        q_bit     = (rem_shift >= {1'b0, den_q});
        quo       = {num_q[NB-2:0], q_bit};

        lane_done = 1'b0;
        lane_val  = '0;

        case (state_q)
            S_IDLE: begin
                if (iValid) begin
                    data_d  = iData;
                    mode_d  = iMode;
                    ch_d    = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (mode_q) begin
                    lane_done = 1'b1;
                    lane_val  = clip_val;
                end else begin
                    // |x| <= 2^(WIDTH-1), so the top magnitude bit never
                    // survives the shift into the NB-bit dividend.
                    num_d   = NB'({cur_abs, {FRAC{1'b0}}});
                    den_d   = UNITY + cur_abs;
                    rem_d   = '0;
                    cnt_d   = CNTW'(NB - 1);
                    neg_d   = cur_neg;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = q_bit ? rem_sub[WIDTH:0] : rem_shift[WIDTH:0];
                num_d = quo;
                if (cnt_q == '0) begin
                    lane_done = 1'b1;
                    lane_val  = neg_q ? WIDTH'(-quo) : WIDTH'(quo);
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            S_DONE: begin
                if (iReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (lane_done) begin
            buf_d[ch_q] = lane_val;
            if (ch_q == LAST_CH) begin
                state_d = S_DONE;
                // Publish all lanes together, including the one finishing now.
                for (int k = 0; k < CHANNELS; k++) begin
                    out_d[k*WIDTH +: WIDTH] = buf_d[k];
                end
            end else begin
                ch_d    = ch_q + CHW'(1);
                state_d = S_LOAD;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rem_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            out_q   <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rem_q   <= rem_d;
            num_q   <= num_d;
            den_q   <= den_d;
            out_q   <= out_d;
            buf_q   <= buf_d;
        end
    end

    assign oReady = (state_q == S_IDLE);
    assign oBusy  = (state_q != S_IDLE);
    assign oValid = (state_q == S_DONE);
    assign oData  = out_q;

endmodule

// File: tb/tb_actuator_array.sv
module tb_actuator_array;

    localparam int W = 16;
    localparam int F = 8;
    localparam int C = 4;

    logic             iClk = 1'b0;
    logic             iRst = 1'b1;
    logic [C*W-1:0]   iData = '0;
    logic             iValid = 1'b0;
    logic             oReady;
    logic             iMode = 1'b0;
    logic [C*W-1:0]   oData;
    logic             oValid;
    logic             iReady = 1'b0;
    logic             oBusy;

    int n_cmp = 0;
    int n_bad = 0;

    actuator_array #(.WIDTH(W), .FRAC(F), .CHANNELS(C)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iData  (iData),
        .iValid (iValid),
        .oReady (oReady),
        .iMode  (iMode),
        .oData  (oData),
        .oValid (oValid),
        .iReady (iReady),
        .oBusy  (oBusy)
    );

    always #5 iClk = ~iClk;

    function automatic logic [C*W-1:0] pk(input int c3, input int c2, input int c1, input int c0);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic accept(input logic [C*W-1:0] d, input logic m);
        iData  = d;
        iMode  = m;
        iValid = 1'b1;
        step();
        iValid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (oValid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic release_out();
        iReady = 1'b1;
        step();
        iReady = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++; if (oReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", oReady); end
        n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", oValid); end
        n_cmp++; if (oBusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", oBusy); end
        n_cmp++; if (oData !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", oData); end
        iRst = 1'b0;
        step();
    endtask

    task automatic test_mode0_basic();
        int n;
        logic [C*W-1:0] exp_d;
        exp_d = pk(192, 0, -128, 128);
        accept(pk(768, 0, -256, 256), 1'b0);
        iData = pk(1, 1, 1, 1);
        iMode = 1'b1;
        n_cmp++; if (oBusy !== 1'b1) begin n_bad++; $display("FAIL m0_busy: got %b want 1", oBusy); end
        n_cmp++; if (oReady !== 1'b0) begin n_bad++; $display("FAIL m0_ready: got %b want 0", oReady); end
        wait_valid(n);
        n_cmp++; if (n != 100) begin n_bad++; $display("FAIL m0_latency: got %0d want 100", n); end
        n_cmp++; if (oData !== exp_d) begin n_bad++; $display("FAIL m0_data: got %h want %h", oData, exp_d); end
        release_out();
        n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL m0_valid_drop: got %b want 0", oValid); end
        n_cmp++; if (oData !== exp_d) begin n_bad++; $display("FAIL m0_data_keep: got %h want %h", oData, exp_d); end
        n_cmp++; if (oReady !== 1'b1) begin n_bad++; $display("FAIL m0_ready_back: got %b want 1", oReady); end
    endtask

    task automatic test_mode0_extremes();
        int n;
        logic [C*W-1:0] exp_d;
        exp_d = pk(-254, 254, 0, 0);
        accept(pk(-32768, 32767, 1, -1), 1'b0);
        wait_valid(n);
        n_cmp++; if (n != 100) begin n_bad++; $display("FAIL m0x_latency: got %0d want 100", n); end
        n_cmp++; if (oData !== exp_d) begin n_bad++; $display("FAIL m0x_data: got %h want %h", oData, exp_d); end
        release_out();
    endtask

    task automatic test_mode1_clamp();
        int n;
        logic [C*W-1:0] exp_d;
        exp_d = pk(-255, 100, -255, 255);
        accept(pk(-255, 100, -300, 300), 1'b1);
        wait_valid(n);
        n_cmp++; if (n != 4) begin n_bad++; $display("FAIL m1_latency: got %0d want 4", n); end
        n_cmp++; if (oData !== exp_d) begin n_bad++; $display("FAIL m1_data: got %h want %h", oData, exp_d); end
        release_out();
        exp_d = pk(255, -255, 255, -255);
        accept(pk(32767, -32768, 255, -256), 1'b1);
        wait_valid(n);
        n_cmp++; if (n != 4) begin n_bad++; $display("FAIL m1b_latency: got %0d want 4", n); end
        n_cmp++; if (oData !== exp_d) begin n_bad++; $display("FAIL m1b_data: got %h want %h", oData, exp_d); end
        release_out();
    endtask

    task automatic test_backpressure();
        int n;
        logic [C*W-1:0] exp_d;
        exp_d = pk(7, -7, 255, -255);
        accept(pk(7, -7, 300, -300), 1'b1);
        wait_valid(n);
        n_cmp++; if (n != 4) begin n_bad++; $display("FAIL bp_latency: got %0d want 4", n); end
        iData = pk(9, 9, 9, 9);
        for (int i = 0; i < 10; i++) begin
            iValid = (i % 2 == 0);
            step();
            n_cmp++;
            if (oValid !== 1'b1 || oReady !== 1'b0 || oData !== exp_d) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                         i, oValid, oReady, oData, exp_d);
            end
        end
        iValid = 1'b0;
        release_out();
        n_cmp++; if (oBusy !== 1'b0 || oReady !== 1'b1) begin n_bad++; $display("FAIL bp_not_accepted: got busy=%b ready=%b want busy=0 ready=1", oBusy, oReady); end
    endtask

    task automatic test_reset_abort();
        int n;
        int seen;
        logic [C*W-1:0] exp_d;
        accept(pk(768, 0, -256, 256), 1'b0);
        for (int i = 0; i < 50; i++) step();
        iRst = 1'b1;
        #2;
        n_cmp++; if (oReady !== 1'b1 || oBusy !== 1'b0 || oValid !== 1'b0) begin n_bad++; $display("FAIL abort_ctrl: got ready=%b busy=%b valid=%b want 1 0 0", oReady, oBusy, oValid); end
        n_cmp++; if (oData !== '0) begin n_bad++; $display("FAIL abort_data: got %h want 0", oData); end
        iRst = 1'b0;
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (oValid === 1'b1) seen = 1;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d want 0", seen); end
        n_cmp++; if (oReady !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", oReady); end
        exp_d = pk(-254, 254, 0, 0);
        accept(pk(-32768, 32767, 1, -1), 1'b0);
        wait_valid(n);
        n_cmp++; if (n != 100) begin n_bad++; $display("FAIL abort_next_latency: got %0d want 100", n); end
        n_cmp++; if (oData !== exp_d) begin n_bad++; $display("FAIL abort_next_data: got %h want %h", oData, exp_d); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [C*W-1:0] vin [3];
        logic [C*W-1:0] vexp [3];
        int acc_cyc [3];
        int hs_cyc [3];
        int acc;
        int hs;
        logic r;
        logic v;
        logic [C*W-1:0] od;
        vin[0] = pk(1000, -1000, 5, -5);  vexp[0] = pk(255, -255, 5, -5);
        vin[1] = pk(0, 256, -256, 255);   vexp[1] = pk(0, 255, -255, 255);
        vin[2] = pk(-1, 2, -3, 4);        vexp[2] = pk(-1, 2, -3, 4);
        for (int i = 0; i < 3; i++) begin acc_cyc[i] = 0; hs_cyc[i] = 0; end
        acc = 0;
        hs = 0;
        iMode  = 1'b1;
        iReady = 1'b1;
        iData  = vin[0];
        iValid = 1'b1;
        for (int cyc = 0; cyc < 100 && hs < 3; cyc++) begin
            r  = oReady;
            v  = oValid;
            od = oData;
            step();
            if (r && acc < 3) begin
                acc_cyc[acc] = cyc;
                acc++;
                if (acc < 3) iData = vin[acc];
                else iValid = 1'b0;
            end
            if (v) begin
                n_cmp++;
                if (od !== vexp[hs]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", hs, od, vexp[hs]); end
                hs_cyc[hs] = cyc;
                hs++;
            end
        end
        iValid = 1'b0;
        iReady = 1'b0;
        n_cmp++; if (hs != 3) begin n_bad++; $display("FAIL b2b_handshakes: got %0d want 3", hs); end
        for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (acc_cyc[i] != hs_cyc[i-1] + 1) begin
                n_bad++;
                $display("FAIL b2b_gap[%0d]: got accept at %0d want %0d", i, acc_cyc[i], hs_cyc[i-1] + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_mode0_extremes();
        test_mode1_clamp();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/actuator_array.md
ACTUATOR_ARRAY -- requirements
Module: actuator_array

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed fixed-point sample width.
REQ-002 SHALL have parameter FRAC, default 8, fractional bits (1.0 = 2^FRAC); 1 <= FRAC <= WIDTH-2.
REQ-003 SHALL have parameter CHANNELS, default 4, samples per transaction.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port iClk  in  1  rising-edge clock.
REQ-006 SHALL have port iRst  in  1  asynchronous active-high reset.
REQ-007 SHALL have port iData  in  CHANNELS*WIDTH  packed signed samples; channel k at [k*WIDTH +: WIDTH].
REQ-008 SHALL have port iValid  in  1  input transaction valid.
REQ-009 SHALL have port oReady  out  1  block can accept a transaction.
REQ-010 SHALL have port iMode  in  1  0 = softsign, 1 = symmetric hard clip.
REQ-011 SHALL have port oData  out  CHANNELS*WIDTH  packed signed results, same lane layout as iData.
REQ-012 SHALL have port oValid  out  1  oData holds a complete result.
REQ-013 SHALL have port iReady  in  1  downstream accepts result.
REQ-014 SHALL have port oBusy  out  1  transaction in progress (state != IDLE).

Function
REQ-015 SHALL implement states IDLE, LOAD, DIV, DONE; oReady = 1 only in IDLE.
REQ-016 SHALL accept on iValid && oReady at a rising edge, capturing all of iData and iMode; later changes ignored until next accept.
REQ-017 Mode 0 SHALL produce per channel y = sign(x) * floor(|x| * 2^FRAC / (2^FRAC + |x|)).
REQ-018 |x| SHALL be formed in WIDTH+1 bits so x = -2^(WIDTH-1) is exact; divisor is never zero; x = 0 gives y = 0.
REQ-019 Mode 0 SHALL use one shared restoring unsigned divider, one quotient bit per cycle, WIDTH+FRAC DIV cycles per channel, channels processed 0 to CHANNELS-1.
REQ-020 Per channel, mode 0 SHALL spend 1 LOAD cycle (operand setup) plus WIDTH+FRAC DIV cycles.
REQ-021 Mode 1 SHALL produce y = clamp(x, -(2^FRAC-1), 2^FRAC-1), one LOAD cycle per channel, no DIV cycles.
REQ-022 oValid SHALL rise exactly CHANNELS*(WIDTH+FRAC+1) cycles after the accept edge in mode 0, and CHANNELS cycles after it in mode 1.
REQ-023 Per-channel results SHALL go to an internal buffer; oData SHALL update atomically on entry to DONE only.
REQ-024 In DONE, oValid = 1; oData and oValid SHALL hold while iReady = 0.
REQ-025 On oValid && iReady, the next state SHALL be IDLE with oValid = 0; no accept in that same cycle (oReady = 0 in DONE).
REQ-026 oData SHALL keep its last value after the output handshake until the next DONE entry.
REQ-027 iValid while oBusy = 1 SHALL be ignored, with no effect on the current transaction.
REQ-028 All results SHALL fit WIDTH bits; in mode 0 |y| <= 2^FRAC-1 for all inputs.

Reset
REQ-029 iRst = 1 SHALL asynchronously force state IDLE, oValid = 0, oBusy = 0, oData = 0, clear the internal buffer and divider; oReady = 1.
REQ-030 Reset mid-transaction SHALL abort it: no oValid and no partial oData; the next accept after release proceeds normally.

Verification (WIDTH=16, FRAC=8, CHANNELS=4)
REQ-031 Mode 0, iData = {768, 0, -256, 256} (ch3..ch0) -> oData = {192, 0, -128, 128}, oValid exactly 100 cycles after accept.
REQ-032 Mode 0, iData = {-32768, 32767, 1, -1} -> oData = {-254, 254, 0, 0}.
REQ-033 Mode 1, iData = {-255, 100, -300, 300} -> oData = {-255, 100, -255, 255}, oValid 4 cycles after accept.
REQ-034 iReady = 0 for 10 cycles in DONE, with iValid pulsed meanwhile -> oData stable, oValid = 1, oReady = 0, and the pulse is not accepted.
REQ-035 iRst pulse 50 cycles into a mode 0 transaction -> oValid never asserts, oReady = 1 after release, and the following transaction gives correct results at the 100-cycle latency.
REQ-036 iValid held high with iReady = 1 -> each new accept occurs one cycle after the previous output handshake, and results match per transaction.
